// File: rtl/write_data_pkg.sv
// Shared definitions for the write_data capture sink.
//   state_t            : FSM encoding (IDLE/CAPTURE/DUMP/DONE = 2'b00..2'b11)
//   DEF_IMAGE_WIDTH    : default pixels per row (even, >= 2)
//   DEF_IMAGE_HEIGHT   : default rows per frame
//   DEF_DATA_WIDTH     : bits per colour channel
//   BYTES_PER_PAIR     : bytes written per even/odd pixel pair
package write_data_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DUMP    = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int DEF_IMAGE_WIDTH  = 768;
  localparam int DEF_IMAGE_HEIGHT = 512;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int BYTES_PER_PAIR   = 6;

endpackage

// File: rtl/frame_buffer_ram.sv
// Frame buffer: one write port that stores LANES consecutive bytes starting at
// wr_addr in a single cycle, and one synchronous byte-wide read port.
// Contents are never reset.
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : address of lane 0; lanes land at wr_addr..wr_addr+LANES-1
//   wr_data  : LANES bytes, lane 0 in the least significant position
//   rd_en    : read strobe; rd_data updates on the next rising edge
//   rd_addr  : byte address to read
//   rd_data  : registered read data (held while rd_en is low)
module frame_buffer_ram #(
  parameter int DEPTH      = 24,
  parameter int ADDR_W     = 5,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 6
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The caller never generates a base whose last lane passes DEPTH-1.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        mem[wr_addr + ADDR_W'(i)] <= wr_data[i];
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/write_data.sv
// Capture sink for the even/odd RGB pixel-pair stream. Pairs are stored
// bottom-up and byte-interleaved (file order), then the whole buffer is
// streamed out byte by byte and completion is flagged.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   horizontal_Pulse    : one pixel pair per high cycle
//   data_{R,G,B}_Even   : even-column pixel channels
//   data_{R,G,B}_Odd    : odd-column pixel channels
//   dump_byte/dump_valid: buffer byte in file order, qualified by dump_valid
//   dump_ready          : consumer ready
//   sig_overrun         : sticky, a pulse arrived during DUMP or DONE
//   sig_write_done      : frame captured and fully dumped
// Handshake: a byte transfers on every rising edge where dump_valid && dump_ready;
// while dump_valid is high and dump_ready low, dump_byte and dump_valid hold.
// dump_valid never depends combinationally on dump_ready.
module write_data
  import write_data_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  horizontal_Pulse,
  input  logic [DATA_WIDTH-1:0] data_Red_Even,
  input  logic [DATA_WIDTH-1:0] data_Green_Even,
  input  logic [DATA_WIDTH-1:0] data_Blue_Even,
  input  logic [DATA_WIDTH-1:0] data_Red_Odd,
  input  logic [DATA_WIDTH-1:0] data_Green_Odd,
  input  logic [DATA_WIDTH-1:0] data_Blue_Odd,
  output logic [DATA_WIDTH-1:0] dump_byte,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  sig_overrun,
  output logic                  sig_write_done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT * 3;
  localparam int ADDR_W     = $clog2(IMAGE_SIZE);
  localparam int AW1        = ADDR_W + 1;
  localparam int COL_W      = $clog2(IMAGE_WIDTH);
  localparam int ROW_W      = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int ROW_BYTES  = IMAGE_WIDTH * 3;

  state_t           state;
  state_t           state_next;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [AW1-1:0]   base_addr;
  logic [AW1-1:0]   rd_ptr;     // reads issued to the buffer
  logic [AW1-1:0]   tx_cnt;     // bytes accepted by the consumer
  logic             s1_valid;   // RAM read register holds an undelivered byte
  logic             last_pair;
  logic             out_ready;
  logic             xfer;
  logic             wr_en;
  logic             rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic             unused_bits;

  assign last_pair = (row == ROW_W'(IMAGE_HEIGHT - 1)) && (col == COL_W'(IMAGE_WIDTH - 2));
  assign out_ready = !dump_valid || dump_ready;
  assign xfer      = dump_valid && dump_ready;

  // Row 0 of the image is the last row of the file (bottom-up storage).
  assign base_addr = AW1'(ROW_BYTES) * (AW1'(IMAGE_HEIGHT - 1) - AW1'(row))
                   + AW1'(3) * AW1'(col);
  assign unused_bits = base_addr[ADDR_W];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, CAPTURE: begin
        if (horizontal_Pulse) begin
          state_next = last_pair ? DUMP : CAPTURE;
        end
      end
      DUMP: begin
        if (xfer && (tx_cnt == AW1'(IMAGE_SIZE - 1))) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    sig_write_done = 1'b0;
    case (state)
      IDLE, CAPTURE: wr_en = horizontal_Pulse;
      // Issue a read only if the read register will be free after this edge.
      DUMP:          rd_en = (rd_ptr != AW1'(IMAGE_SIZE)) && (!s1_valid || out_ready);
      DONE:          sig_write_done = 1'b1;
      default:       ;
    endcase
  end

  // Capture counters: gaps hold them, the final pair returns them to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (wr_en) begin
      if (last_pair) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_W'(IMAGE_WIDTH - 2)) begin
        row <= row + ROW_W'(1);
        col <= '0;
      end else begin
        col <= col + COL_W'(2);
      end
    end
  end

  // Dump pipeline: RAM read register (s1) followed by the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      tx_cnt     <= '0;
      s1_valid   <= 1'b0;
      dump_valid <= 1'b0;
      dump_byte  <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW1'(1);
      end
      if (xfer) begin
        tx_cnt <= tx_cnt + AW1'(1);
      end
      if (rd_en) begin
        s1_valid <= 1'b1;
      end else if (out_ready) begin
        s1_valid <= 1'b0;
      end
      if (out_ready) begin
        dump_valid <= s1_valid && (state == DUMP);
        if (s1_valid) begin
          dump_byte <= rd_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_overrun <= 1'b0;
    end else if (horizontal_Pulse && ((state == DUMP) || (state == DONE))) begin
      sig_overrun <= 1'b1;
    end
  end

  frame_buffer_ram #(
    .DEPTH      (IMAGE_SIZE),
    .ADDR_W     (ADDR_W),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (BYTES_PER_PAIR)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (base_addr[ADDR_W-1:0]),
    .wr_data ({data_Blue_Odd, data_Green_Odd, data_Red_Odd,
               data_Blue_Even, data_Green_Even, data_Red_Even}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_write_data.sv
module tb_write_data;
  import write_data_pkg::*;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int SIZE  = W * H * 3;
  localparam int PAIRS = W * H / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       horizontal_Pulse;
  logic [7:0] data_Red_Even, data_Green_Even, data_Blue_Even;
  logic [7:0] data_Red_Odd, data_Green_Odd, data_Blue_Odd;
  logic [7:0] dump_byte;
  logic       dump_valid;
  logic       dump_ready;
  logic       sig_overrun;
  logic       sig_write_done;

  write_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .horizontal_Pulse (horizontal_Pulse),
    .data_Red_Even    (data_Red_Even),
    .data_Green_Even  (data_Green_Even),
    .data_Blue_Even   (data_Blue_Even),
    .data_Red_Odd     (data_Red_Odd),
    .data_Green_Odd   (data_Green_Odd),
    .data_Blue_Odd    (data_Blue_Odd),
    .dump_byte        (dump_byte),
    .dump_valid       (dump_valid),
    .dump_ready       (dump_ready),
    .sig_overrun      (sig_overrun),
    .sig_write_done   (sig_write_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame  [H][W][3];   // model image: [row][col][R,G,B]
  logic [7:0] pairs  [PAIRS][6];  // stimulus: R,G,B even then R,G,B odd
  logic [7:0] dumped [SIZE];

  typedef struct {
    logic [7:0] px [6];
    int         exp_base;
  } vec_t;
  vec_t vt [PAIRS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic set_bus(input int k);
    data_Red_Even   = pairs[k][0];
    data_Green_Even = pairs[k][1];
    data_Blue_Even  = pairs[k][2];
    data_Red_Odd    = pairs[k][3];
    data_Green_Odd  = pairs[k][4];
    data_Blue_Odd   = pairs[k][5];
  endtask

  task automatic random_bus();
    data_Red_Even   = 8'($urandom);
    data_Green_Even = 8'($urandom);
    data_Blue_Even  = 8'($urandom);
    data_Red_Odd    = 8'($urandom);
    data_Green_Odd  = 8'($urandom);
    data_Blue_Odd   = 8'($urandom);
  endtask

  task automatic fill_pairs(input bit random_mode);
    for (int k = 0; k < PAIRS; k++) begin
      for (int j = 0; j < 6; j++) begin
        pairs[k][j] = random_mode ? 8'($urandom) : vt[k].px[j];
      end
    end
  endtask

  // Expected dump: file byte a belongs to file row a/(3W), i.e. image row
  // H-1-a/(3W); within that row, pixel (a%(3W))/3 and channel (a%(3W))%3.
  task automatic build_expected();
    int fr, off;
    exp_q.delete();
    for (int a = 0; a < SIZE; a++) begin
      fr  = a / (W * 3);
      off = a % (W * 3);
      exp_q.push_back(frame[H - 1 - fr][off / 3][off % 3]);
    end
  endtask

  task automatic do_reset(input bit with_pulses);
    reset = 1'b1;
    dump_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      horizontal_Pulse = with_pulses;
      random_bus();
      @(negedge clk);
      check("reset_dump_byte", dump_byte, 8'h00);
      check("reset_dump_valid", dump_valid, 1'b0);
      check("reset_overrun", sig_overrun, 1'b0);
      check("reset_done", sig_write_done, 1'b0);
    end
    horizontal_Pulse = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state_idle", dut.state, IDLE);
  endtask

  task automatic capture_frame(input int gap, input int npairs);
    int r, c;
    for (int k = 0; k < npairs; k++) begin
      if (k > 0) repeat (gap) @(negedge clk);
      set_bus(k);
      horizontal_Pulse = 1'b1;
      @(negedge clk);
      horizontal_Pulse = 1'b0;
      r = k / (W / 2);
      c = 2 * (k % (W / 2));
      for (int ch = 0; ch < 3; ch++) begin
        frame[r][c][ch]     = pairs[k][ch];
        frame[r][c + 1][ch] = pairs[k][3 + ch];
      end
      if (k < PAIRS - 1) begin
        check("capture_state", dut.state, CAPTURE);
        check("capture_no_valid", dump_valid, 1'b0);
      end
    end
    build_expected();
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic run_dump(input int mode, input bit poke);
    int         cyc, got;
    bit         prev_stall, ov_exp;
    logic [7:0] prev_b, e;
    cyc = 0; got = 0; prev_stall = 1'b0; ov_exp = 1'b0; prev_b = 8'h00;
    check("dump_entry_state", dut.state, DUMP);
    while (got < SIZE && cyc < 400) begin
      if (cyc <= 1) check("valid_before_rise", dump_valid, 1'b0);
      if (cyc == 2) check("valid_rise", dump_valid, 1'b1);
      check("overrun_flag", sig_overrun, ov_exp);
      check("done_early", sig_write_done, 1'b0);
      if (prev_stall) begin
        check("stall_valid", dump_valid, 1'b1);
        check("stall_byte", dump_byte, prev_b);
      end
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 5) begin
        random_bus();
        horizontal_Pulse = 1'b1;
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", got, SIZE);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("dump_byte[%0d]", got), dump_byte, e);
        end
        dumped[got] = dump_byte;
        got++;
      end
      prev_stall = dump_valid && !dump_ready;
      prev_b     = dump_byte;
      @(negedge clk);
      cyc++;
      if (horizontal_Pulse) ov_exp = 1'b1;
      horizontal_Pulse = 1'b0;
    end
    check("dump_count", got, SIZE);
    check("done_rise", sig_write_done, 1'b1);
    check("valid_drop", dump_valid, 1'b0);
    check("done_state", dut.state, DONE);
    check("exp_drained", exp_q.size(), 0);
    dump_ready = 1'b1;
    if (poke) begin
      random_bus();
      horizontal_Pulse = 1'b1;
      @(negedge clk);
      horizontal_Pulse = 1'b0;
      ov_exp = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("done_hold", sig_write_done, 1'b1);
    check("done_no_valid", dump_valid, 1'b0);
    check("done_overrun", sig_overrun, ov_exp);
  endtask

  task automatic check_table();
    for (int i = 0; i < PAIRS; i++) begin
      for (int j = 0; j < 6; j++) begin
        check($sformatf("table_pair%0d_byte%0d", i, j), dumped[vt[i].exp_base + j], vt[i].px[j]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    horizontal_Pulse = 1'b0;
    dump_ready = 1'b0;
    data_Red_Even = 8'h00; data_Green_Even = 8'h00; data_Blue_Even = 8'h00;
    data_Red_Odd  = 8'h00; data_Green_Odd  = 8'h00; data_Blue_Odd  = 8'h00;

    // Pair p carries pixels k=2p (even) and k+1 (odd), pixel k = (k, k+16, k+32).
    // Row 0 (pairs 0,1) lands at file bytes 12..23, row 1 (pairs 2,3) at 0..11.
    for (int p = 0; p < PAIRS; p++) begin
      vt[p].px[0] = 8'(2 * p);
      vt[p].px[1] = 8'(2 * p + 16);
      vt[p].px[2] = 8'(2 * p + 32);
      vt[p].px[3] = 8'(2 * p + 1);
      vt[p].px[4] = 8'(2 * p + 17);
      vt[p].px[5] = 8'(2 * p + 33);
    end
    vt[0].exp_base = 12;
    vt[1].exp_base = 18;
    vt[2].exp_base = 0;
    vt[3].exp_base = 6;

    // Reset held with pulses applied
    do_reset(1'b1);

    // Back-to-back table frame
    fill_pairs(1'b0);
    capture_frame(0, PAIRS);
    run_dump(0, 1'b0);
    check_table();

    // Same frame with 3-cycle gaps
    do_reset(1'b0);
    fill_pairs(1'b0);
    capture_frame(3, PAIRS);
    run_dump(0, 1'b0);
    check_table();

    // Ready pattern 1,0,0,1 on a random frame
    do_reset(1'b0);
    fill_pairs(1'b1);
    capture_frame(0, PAIRS);
    run_dump(1, 1'b0);

    // Pulses during DUMP and DONE
    do_reset(1'b0);
    fill_pairs(1'b1);
    capture_frame(1, PAIRS);
    run_dump(2, 1'b1);

    // Reset after two pairs, then a complete new frame
    do_reset(1'b0);
    fill_pairs(1'b1);
    capture_frame(0, 2);
    do_reset(1'b0);
    fill_pairs(1'b1);
    capture_frame(0, PAIRS);
    run_dump(0, 1'b0);

    // Random frames, gaps and backpressure
    for (int n = 0; n < 3; n++) begin
      do_reset(1'b0);
      fill_pairs(1'b1);
      capture_frame(int'($urandom_range(0, 4)), PAIRS);
      run_dump(2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
